// File: rtl/snos_rate_seq_pkg.sv
// Shared types for the SNOS rate sequencer: FSM state encoding, PLL select pair
// and the mcu_f to NB3N502 select lookup.
package common;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_RUN    = 3'd1,
    ST_MUTE   = 3'd2,
    ST_DRST   = 3'd3,
    ST_RECONF = 3'd4,
    ST_LOCK   = 3'd5,
    ST_REL    = 3'd6
  } snos_state_e;

  typedef struct packed {
    logic [1:0] val;
    logic [1:0] oe;
  } pll_sel_t;

  localparam pll_sel_t PLL_SEL_RST = '{val: 2'b00, oe: 2'b11};

  // x3 needs S1 floating, hence oe bit 1 cleared for mcu_f = 11
  function automatic pll_sel_t pll_lookup(input logic [1:0] f);
    pll_sel_t sel;
    case (f)
      2'b00:   sel = '{val: 2'b00, oe: 2'b11};
      2'b01:   sel = '{val: 2'b10, oe: 2'b11};
      2'b10:   sel = '{val: 2'b01, oe: 2'b11};
      2'b11:   sel = '{val: 2'b00, oe: 2'b01};
      default: sel = PLL_SEL_RST;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/snos_cfg_filter.sv
// Two-flop synchronizer plus run-length stability filter for the MCU rate config.
// cfg_stable only takes a value the synchronized input held for STABLE_CYC cycles.
module snos_cfg_filter #(
  parameter int               WIDTH      = 3,
  parameter int               STABLE_CYC = 240,
  parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] cfg_async,
  output logic [WIDTH-1:0] cfg_stable,
  output logic             cfg_upd
);

  localparam logic [15:0] STABLE_N = 16'(STABLE_CYC);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [15:0]      run_q;
  logic [15:0]      run_d;
  logic             upd_q;
  logic             upd_d;
  logic             accept_s;

  // Run length of the synchronized value; any change restarts it at one
  always_comb begin
    run_d = 16'd1;
    if (meta_q == sync_q) begin
      run_d = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
    end else begin
      run_d = 16'd1;
    end
  end

  // Accept a new stable value and flag the cycle it changes
  always_comb begin
    accept_s = (run_q >= STABLE_N);
    stable_d = stable_q;
    upd_d    = 1'b0;
    if (accept_s && (sync_q != stable_q)) begin
      stable_d = sync_q;
      upd_d    = 1'b1;
    end else begin
      stable_d = stable_q;
      upd_d    = 1'b0;
    end
  end

  // Synchronizer, run counter and stable value registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q   <= {WIDTH{1'b0}};
      sync_q   <= {WIDTH{1'b0}};
      run_q    <= 16'd0;
      stable_q <= RST_VAL;
      upd_q    <= 1'b0;
    end else begin
      meta_q   <= cfg_async;
      sync_q   <= meta_q;
      run_q    <= run_d;
      stable_q <= stable_d;
      upd_q    <= upd_d;
    end
  end

  assign cfg_stable = stable_q;
  assign cfg_upd    = upd_q;

endmodule

// File: rtl/snos_rate_seq.sv
// Sample-rate change sequencer for the DAC and NB3N502 PLL: mute, DAC reset,
// PLL reprogram, lock wait, release. Optional DSD handling under SNOS_DSD_EN.
module snos_rate_seq #(
  parameter int STABLE_CYC = 240,
  parameter int MUTE_CYC   = 2400,
  parameter int RST_CYC    = 240,
  parameter int LOCK_CYC   = 24000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mcu_44_48,
  input  logic [1:0] mcu_f,
  input  logic       mcu_dsd_on,
  input  logic       mcu_mute,
  input  logic       mcu_dac_reset,
  output logic       dac_44_48,
  output logic [1:0] dac_f,
  output logic       dac_dsd,
  output logic       dac_mute,
  output logic       dac_reset,
  output logic [1:0] pll_s_val,
  output logic [1:0] pll_s_oe,
  output logic       busy
);

  import common::*;

`ifdef SNOS_DSD_EN
  localparam int               CFG_W   = 4;
  localparam logic [CFG_W-1:0] CFG_RST = 4'b0001;
`else
  localparam int               CFG_W   = 3;
  localparam logic [CFG_W-1:0] CFG_RST = 3'b000;
`endif

  localparam logic [15:0] MUTE_LD = 16'(MUTE_CYC - 1);
  localparam logic [15:0] RST_LD  = 16'(RST_CYC - 1);
  localparam logic [15:0] LOCK_LD = 16'(LOCK_CYC - 1);

  logic [CFG_W-1:0] cfg_async_s;
  logic [CFG_W-1:0] cfg_stable_s;
  logic             cfg_upd_s;
  logic             pending_s;
  logic             restart_s;
  logic [CFG_W-1:0] applied_q;
  logic [CFG_W-1:0] applied_d;
  logic             mute_meta_q;
  logic             mute_sync_q;
  logic             drst_meta_q;
  logic             drst_sync_q;
  snos_state_e      state_q;
  snos_state_e      state_d;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_d;
  pll_sel_t         pll_q;
  pll_sel_t         pll_d;
  logic             busy_q;
  logic             busy_d;
  logic             seq_rst_q;
  logic             seq_rst_d;

`ifdef SNOS_DSD_EN
  assign cfg_async_s = {mcu_44_48, mcu_f, mcu_dsd_on};
  assign dac_dsd     = applied_q[0];
`else
  logic unused_dsd;
  assign unused_dsd  = mcu_dsd_on;
  assign cfg_async_s = {mcu_44_48, mcu_f};
  assign dac_dsd     = 1'b1;
`endif

  snos_cfg_filter #(
    .WIDTH      (CFG_W),
    .STABLE_CYC (STABLE_CYC),
    .RST_VAL    (CFG_RST)
  ) u_cfg_filter (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_async  (cfg_async_s),
    .cfg_stable (cfg_stable_s),
    .cfg_upd    (cfg_upd_s)
  );

  // Inside DRST/RECONF the pending level is expected, so only a fresh update restarts
  assign pending_s = (cfg_stable_s != applied_q);
  assign restart_s = cfg_upd_s & pending_s;

  // Sequencer next state, shared down-counter and RECONF latching
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != 16'd0) ? cnt_q - 16'd1 : 16'd0;
    applied_d = applied_q;
    pll_d     = pll_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_MUTE;
        cnt_d   = MUTE_LD;
      end
      ST_RUN: begin
        if (pending_s) begin
          state_d = ST_MUTE;
          cnt_d   = MUTE_LD;
        end else begin
          state_d = ST_RUN;
          cnt_d   = 16'd0;
        end
      end
      ST_MUTE: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_DRST;
          cnt_d   = RST_LD;
        end else begin
          state_d = ST_MUTE;
        end
      end
      ST_DRST: begin
        if (restart_s) begin
          state_d = ST_DRST;
          cnt_d   = RST_LD;
        end else if (cnt_q == 16'd0) begin
          state_d = ST_RECONF;
          cnt_d   = 16'd0;
        end else begin
          state_d = ST_DRST;
        end
      end
      ST_RECONF: begin
        applied_d = cfg_stable_s;
        pll_d     = pll_lookup(cfg_stable_s[CFG_W-2 -: 2]);
        if (restart_s) begin
          state_d = ST_DRST;
          cnt_d   = RST_LD;
        end else begin
          state_d = ST_LOCK;
          cnt_d   = LOCK_LD;
        end
      end
      ST_LOCK: begin
        if (pending_s) begin
          state_d = ST_DRST;
          cnt_d   = RST_LD;
        end else if (cnt_q == 16'd0) begin
          state_d = ST_REL;
          cnt_d   = 16'd0;
        end else begin
          state_d = ST_LOCK;
        end
      end
      ST_REL: begin
        if (pending_s) begin
          state_d = ST_DRST;
          cnt_d   = RST_LD;
        end else begin
          state_d = ST_RUN;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Output flags follow the next state so they line up with state_q
  always_comb begin
    busy_d    = (state_d != ST_RUN);
    seq_rst_d = 1'b0;
    if ((state_d == ST_DRST) || (state_d == ST_RECONF) || (state_d == ST_LOCK)) begin
      seq_rst_d = 1'b1;
    end else begin
      seq_rst_d = 1'b0;
    end
  end

  // State, counter, applied config and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= 16'd0;
      applied_q   <= CFG_RST;
      pll_q       <= PLL_SEL_RST;
      busy_q      <= 1'b1;
      seq_rst_q   <= 1'b1;
      mute_meta_q <= 1'b0;
      mute_sync_q <= 1'b0;
      drst_meta_q <= 1'b0;
      drst_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      applied_q   <= applied_d;
      pll_q       <= pll_d;
      busy_q      <= busy_d;
      seq_rst_q   <= seq_rst_d;
      mute_meta_q <= mcu_mute;
      mute_sync_q <= mute_meta_q;
      drst_meta_q <= mcu_dac_reset;
      drst_sync_q <= drst_meta_q;
    end
  end

  assign dac_44_48 = applied_q[CFG_W-1];
  assign dac_f     = applied_q[CFG_W-2 -: 2];
  assign busy      = busy_q;
  assign dac_mute  = busy_q | mute_sync_q;
  assign dac_reset = seq_rst_q | drst_sync_q;
  assign pll_s_val = pll_q.val;
  assign pll_s_oe  = pll_q.oe;

endmodule

// File: tb/tb_snos_rate_seq.sv
// Self-checking bench for snos_rate_seq with shortened timing parameters.
module tb_snos_rate_seq;

  localparam int STABLE_CYC = 4;
  localparam int MUTE_CYC   = 8;
  localparam int RST_CYC    = 4;
  localparam int LOCK_CYC   = 16;
  localparam int SEQ_CYC    = MUTE_CYC + RST_CYC + 1 + LOCK_CYC + 1;
  localparam int RST_WIN    = RST_CYC + 1 + LOCK_CYC;
`ifdef SNOS_DSD_EN
  localparam bit DSD_EN = 1'b1;
`else
  localparam bit DSD_EN = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       mcu_44_48;
  logic [1:0] mcu_f;
  logic       mcu_dsd_on;
  logic       mcu_mute;
  logic       mcu_dac_reset;
  logic       dac_44_48;
  logic [1:0] dac_f;
  logic       dac_dsd;
  logic       dac_mute;
  logic       dac_reset;
  logic [1:0] pll_s_val;
  logic [1:0] pll_s_oe;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // monitor bookkeeping (written only by the monitor process)
  int         seq_cnt       = 0;
  int         mute_rise_cnt = 0;
  int         busy_len_cur  = 0;
  int         busy_len_last = 0;
  int         rst_len_cur   = 0;
  int         rst_len_last  = 0;
  logic [1:0] pll_at_rst    = 2'b00;
  logic       mute_at_rise  = 1'b0;
  logic       p_busy        = 1'b1;
  logic       p_mute        = 1'b1;
  logic       p_rst         = 1'b1;

  snos_rate_seq #(
    .STABLE_CYC (STABLE_CYC),
    .MUTE_CYC   (MUTE_CYC),
    .RST_CYC    (RST_CYC),
    .LOCK_CYC   (LOCK_CYC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mcu_44_48     (mcu_44_48),
    .mcu_f         (mcu_f),
    .mcu_dsd_on    (mcu_dsd_on),
    .mcu_mute      (mcu_mute),
    .mcu_dac_reset (mcu_dac_reset),
    .dac_44_48     (dac_44_48),
    .dac_f         (dac_f),
    .dac_dsd       (dac_dsd),
    .dac_mute      (dac_mute),
    .dac_reset     (dac_reset),
    .pll_s_val     (pll_s_val),
    .pll_s_oe      (pll_s_oe),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // NB3N502 select table: x2, x4, x5, x3 (S1 floating)
  function automatic logic [1:0] ref_val(input logic [1:0] f);
    logic [1:0] tbl [4];
    tbl = '{2'b00, 2'b10, 2'b01, 2'b00};
    return tbl[f];
  endfunction

  function automatic logic [1:0] ref_oe(input logic [1:0] f);
    logic [1:0] tbl [4];
    tbl = '{2'b11, 2'b11, 2'b11, 2'b01};
    return tbl[f];
  endfunction

  // Window and ordering monitor sampled away from the active edge
  always @(negedge clk) begin
    if (!reset_n) begin
      p_busy       <= 1'b1;
      p_mute       <= 1'b1;
      p_rst        <= 1'b1;
      busy_len_cur <= 0;
      rst_len_cur  <= 0;
    end else begin
      if (busy && !p_busy) seq_cnt <= seq_cnt + 1;
      if (dac_mute && !p_mute) mute_rise_cnt <= mute_rise_cnt + 1;
      if (busy) begin
        busy_len_cur <= busy_len_cur + 1;
      end else if (p_busy) begin
        busy_len_last <= busy_len_cur;
        busy_len_cur  <= 0;
      end
      if (dac_reset) begin
        rst_len_cur <= rst_len_cur + 1;
        pll_at_rst  <= pll_s_val;
        if (!p_rst) mute_at_rise <= p_mute;
      end else if (p_rst) begin
        rst_len_last <= rst_len_cur;
        rst_len_cur  <= 0;
      end
      p_busy <= busy;
      p_mute <= dac_mute;
      p_rst  <= dac_reset;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input logic lvl, input int max_cyc, input string tag);
    int i;
    i = 0;
    while (busy !== lvl && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    check_eq(tag, {31'd0, busy}, {31'd0, lvl});
  endtask

  task automatic wait_rst_high(input int max_cyc, input string tag);
    int i;
    i = 0;
    while (dac_reset !== 1'b1 && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    check_eq(tag, {31'd0, dac_reset}, 32'd1);
  endtask

  task automatic set_cfg(input logic [2:0] c);
    mcu_44_48 = c[2];
    mcu_f     = c[1:0];
  endtask

  task automatic check_applied(input string tag, input logic [2:0] c);
    check_eq({tag, "_4448"}, {31'd0, dac_44_48}, {31'd0, c[2]});
    check_eq({tag, "_f"},    {30'd0, dac_f},     {30'd0, c[1:0]});
    check_eq({tag, "_val"},  {30'd0, pll_s_val}, {30'd0, ref_val(c[1:0])});
    check_eq({tag, "_oe"},   {30'd0, pll_s_oe},  {30'd0, ref_oe(c[1:0])});
    check_eq({tag, "_busy"}, {31'd0, busy},      32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         s0;
    int         m0;
    logic [2:0] app;
    logic [2:0] cur;
    logic [2:0] nxt;

    reset_n       = 1'b0;
    mcu_44_48     = 1'b0;
    mcu_f         = 2'b01;
    mcu_dsd_on    = 1'b1;
    mcu_mute      = 1'b0;
    mcu_dac_reset = 1'b0;
    tick(3);

    // reset values
    check_eq("rst_mute",  {31'd0, dac_mute},  32'd1);
    check_eq("rst_dacrst", {31'd0, dac_reset}, 32'd1);
    check_eq("rst_busy",  {31'd0, busy},      32'd1);
    check_eq("rst_f",     {30'd0, dac_f},     32'd0);
    check_eq("rst_4448",  {31'd0, dac_44_48}, 32'd0);
    check_eq("rst_dsd",   {31'd0, dac_dsd},   32'd1);
    check_eq("rst_val",   {30'd0, pll_s_val}, 32'd0);
    check_eq("rst_oe",    {30'd0, pll_s_oe},  32'd3);

    // startup with mcu_f = 01
    reset_n = 1'b1;
    tick(1);
    check_eq("s1_mute_held", {31'd0, dac_mute}, 32'd1);
    wait_busy(1'b0, 100, "s1_run");
    tick(1);
    check_applied("s1", 3'b001);
    check_eq("s1_mute_run", {31'd0, dac_mute}, 32'd0);
    check_eq("s1_dacrst",   {31'd0, dac_reset}, 32'd0);
    app = 3'b001;

    // 01 -> 10: full sequence, window lengths and ordering
    s0 = seq_cnt;
    set_cfg(3'b010);
    wait_busy(1'b1, 40, "s2_start");
    wait_busy(1'b0, 80, "s2_end");
    tick(2);
    check_eq("s2_seq",       seq_cnt - s0, 32'd1);
    check_eq("s2_busy_len",  busy_len_last, SEQ_CYC);
    check_eq("s2_rst_len",   rst_len_last, RST_WIN);
    check_eq("s2_mute_first", {31'd0, mute_at_rise}, 32'd1);
    check_eq("s2_pll_in_rst", {30'd0, pll_at_rst}, 32'd1);
    check_applied("s2", 3'b010);
    app = 3'b010;

    // 2-cycle glitch is filtered
    s0 = seq_cnt;
    set_cfg(3'b000);
    tick(2);
    set_cfg(3'b010);
    tick(40);
    check_eq("s3_seq", seq_cnt - s0, 32'd0);
    check_applied("s3", app);

    // change during LOCK restarts at DRST inside one mute window
    s0 = seq_cnt;
    m0 = mute_rise_cnt;
    set_cfg(3'b000);
    wait_busy(1'b1, 40, "s4_start");
    wait_rst_high(40, "s4_drst");
    tick(7);
    set_cfg(3'b011);
    wait_busy(1'b0, 150, "s4_end");
    tick(2);
    check_eq("s4_seq",      seq_cnt - s0, 32'd1);
    check_eq("s4_mute_win", mute_rise_cnt - m0, 32'd1);
    check_eq("s4_rst_ext",  {31'd0, (rst_len_last > RST_WIN)}, 32'd1);
    check_applied("s4", 3'b011);
    app = 3'b011;

    // mcu_dac_reset pulse in RUN: 2-cycle delayed, no state change
    s0 = seq_cnt;
    mcu_dac_reset = 1'b1;
    tick(1);
    check_eq("s5_drst_d1", {31'd0, dac_reset}, 32'd0);
    tick(1);
    check_eq("s5_drst_d2", {31'd0, dac_reset}, 32'd1);
    tick(1);
    check_eq("s5_drst_d3", {31'd0, dac_reset}, 32'd1);
    mcu_dac_reset = 1'b0;
    tick(1);
    check_eq("s5_drst_d4", {31'd0, dac_reset}, 32'd1);
    tick(1);
    check_eq("s5_drst_off", {31'd0, dac_reset}, 32'd0);
    check_eq("s5_busy", {31'd0, busy}, 32'd0);

    // mcu_mute passes through in RUN
    mcu_mute = 1'b1;
    tick(1);
    check_eq("s5_mute_d1", {31'd0, dac_mute}, 32'd0);
    tick(1);
    check_eq("s5_mute_d2", {31'd0, dac_mute}, 32'd1);
    mcu_mute = 1'b0;
    tick(3);
    check_eq("s5_mute_off", {31'd0, dac_mute}, 32'd0);
    check_eq("s5_seq", seq_cnt - s0, 32'd0);

    // mcu_dsd_on toggle
    s0 = seq_cnt;
    mcu_dsd_on = 1'b0;
    tick(80);
    check_eq("s6_seq", seq_cnt - s0, DSD_EN ? 32'd1 : 32'd0);
    check_eq("s6_dsd", {31'd0, dac_dsd}, DSD_EN ? 32'd0 : 32'd1);
    check_eq("s6_busy", {31'd0, busy}, 32'd0);
    mcu_dsd_on = 1'b1;
    tick(80);
    check_eq("s6_dsd_back", {31'd0, dac_dsd}, 32'd1);

    // reset mid-sequence restarts from INIT defaults
    set_cfg(3'b101);
    wait_rst_high(60, "s7_drst");
    tick(3);
    reset_n = 1'b0;
    tick(2);
    check_eq("s7_rst_f",    {30'd0, dac_f},     32'd0);
    check_eq("s7_rst_4448", {31'd0, dac_44_48}, 32'd0);
    check_eq("s7_rst_val",  {30'd0, pll_s_val}, 32'd0);
    check_eq("s7_rst_oe",   {30'd0, pll_s_oe},  32'd3);
    check_eq("s7_rst_busy", {31'd0, busy},      32'd1);
    reset_n = 1'b1;
    tick(1);
    wait_busy(1'b0, 100, "s7_run");
    tick(1);
    check_applied("s7", 3'b101);
    app = 3'b101;
    cur = 3'b101;

    // randomized holds and glitches against the applied-config model
    for (int it = 0; it < 12; it++) begin
      s0 = seq_cnt;
      if ($urandom_range(0, 2) == 0) begin
        nxt = cur ^ 3'($urandom_range(1, 7));
        set_cfg(nxt);
        tick($urandom_range(1, 2));
        set_cfg(cur);
        tick(50);
        check_eq("rnd_glitch_seq", seq_cnt - s0, 32'd0);
        check_applied("rnd_glitch", app);
      end else begin
        nxt = 3'($urandom_range(0, 7));
        set_cfg(nxt);
        tick(80);
        check_eq("rnd_hold_seq", seq_cnt - s0, (nxt != app) ? 32'd1 : 32'd0);
        check_applied("rnd_hold", nxt);
        check_eq("rnd_hold_mute", {31'd0, dac_mute}, 32'd0);
        app = nxt;
        cur = nxt;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
